// File: rtl/hysteresis_stream.sv
// Streaming hysteresis stage of the Canny pipeline.
// Turns each (magnitude, quantised angle) pixel, in raster order, into a binary
// edge pixel. Strong pixels are edges outright; weak pixels become edges when
// the one neighbour chosen by the angle has already been decided as an edge.
// Earlier decisions come from a left-flag register and a one-row flag buffer.
module hysteresis_stream #(
  parameter int DATA_W   = 8,
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int LOW_DEF  = 10,
  parameter int HIGH_DEF = 50
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              thresh_load,
  input  logic [DATA_W-1:0] thresh_low,
  input  logic [DATA_W-1:0] thresh_high,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_mag,
  input  logic [1:0]        in_angle,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pixel,
  output logic              out_last,
  output logic              frame_done,
  output logic              busy
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_low;
  logic [DATA_W-1:0] r_high;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic              r_left;
  logic              r_ul;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_pixel;
  logic              r_out_last;
  logic              r_frame_done;
  logic              r_lbuf [IMG_W];

  logic              w_in_ready;
  logic              w_accept;
  logic              w_handoff;
  logic              w_first_row;
  logic              w_first_col;
  logic              w_last_col;
  logic              w_last_px;
  logic [COL_W-1:0]  w_col_nx;
  logic              w_up;
  logic              w_up_right;
  logic              w_nflag;
  logic              w_edge;

  // Strong pixels are edges; weak pixels need an edge neighbour.
  function automatic logic edge_rule(input logic [DATA_W-1:0] mag,
                                     input logic [DATA_W-1:0] low,
                                     input logic [DATA_W-1:0] high,
                                     input logic              nflag);
    return (mag >= high) | ((mag >= low) & nflag);
  endfunction

  // A start pulse aborts or begins a frame, so it wins over a coincident pixel.
  assign w_in_ready  = (r_state == S_RUN) & (~r_out_valid | out_ready);
  assign w_accept    = in_valid & w_in_ready & ~start;
  assign w_handoff   = r_out_valid & out_ready;
  assign w_first_row = (r_row == '0);
  assign w_first_col = (r_col == '0);
  assign w_last_col  = (r_col == COL_LAST);
  assign w_last_px   = w_last_col & (r_row == ROW_LAST);
  // Wrapped index keeps the upper-right read inside the buffer; it is masked at the last column.
  assign w_col_nx    = w_last_col ? '0 : r_col + COL_W'(1);
  assign w_up        = r_lbuf[r_col];
  assign w_up_right  = r_lbuf[w_col_nx];

  // Pick the already-decided neighbour flag named by the angle; outside the image reads as 0.
  always_comb begin
    w_nflag = 1'b0;
    case (in_angle)
      2'd0:    w_nflag = ~w_first_col & r_left;
      2'd1:    w_nflag = ~w_first_row & ~w_first_col & r_ul;
      2'd2:    w_nflag = ~w_first_row & w_up;
      default: w_nflag = ~w_first_row & ~w_last_col & w_up_right;
    endcase
  end

  assign w_edge = edge_rule(in_mag, r_low, r_high, w_nflag);

  // Control, position counters, neighbour flags and the output register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= S_IDLE;
      r_low        <= DATA_W'(LOW_DEF);
      r_high       <= DATA_W'(HIGH_DEF);
      r_row        <= '0;
      r_col        <= '0;
      r_left       <= 1'b0;
      r_ul         <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_pixel  <= '0;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if ((r_state == S_IDLE) && thresh_load) begin
        r_low  <= thresh_low;
        r_high <= thresh_high;
      end
      if (start) begin
        r_state     <= S_RUN;
        r_row       <= '0;
        r_col       <= '0;
        r_left      <= 1'b0;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_pixel <= {DATA_W{w_edge}};
        r_out_last  <= w_last_px;
        r_left      <= w_edge;
        // Old slot content is (r-1,c); it becomes the upper-left flag of the next pixel.
        r_ul        <= w_up;
        if (w_last_col) begin
          r_col <= '0;
          r_row <= r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
        if (w_last_px) begin
          r_state <= S_DRAIN;
        end
      end else if (w_handoff) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        if (r_state == S_DRAIN) begin
          r_state      <= S_IDLE;
          r_frame_done <= 1'b1;
        end
      end
    end
  end

  // Previous-row edge flags; row 0 never reads them, so no clearing is needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lbuf[r_col] <= w_edge;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_pixel  = r_out_pixel;
  assign out_last   = r_out_last;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != S_IDLE);

endmodule
